// File: rtl/inst_dispatcher.sv
// inst_dispatcher: instruction FIFO and one-at-a-time issue sequencer for the systolic-array control unit
// Ports: clk/reset_n (async active-low); s_inst_valid/s_inst_ready/s_inst_data host push handshake;
// flush drops queued entries; cu_idle_flag/cu_instruction control-unit side;
// busy, queue_count, done_count, err_timeout status.
module inst_dispatcher #(
  parameter int INST_BITS = 68,
  parameter int OPCODE_BITS = 4,
  parameter logic [OPCODE_BITS-1:0] IDLE_OPCODE = 4'h0,
  parameter int QUEUE_DEPTH = 8,
  parameter int ACCEPT_TIMEOUT = 256
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             s_inst_valid,
  output logic                             s_inst_ready,
  input  logic [INST_BITS-1:0]             s_inst_data,
  input  logic                             flush,
  input  logic                             cu_idle_flag,
  output logic [INST_BITS-1:0]             cu_instruction,
  output logic                             busy,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count,
  output logic [15:0]                      done_count,
  output logic                             err_timeout
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [INST_BITS-1:0] IDLE_WORD = {IDLE_OPCODE, {(INST_BITS-OPCODE_BITS){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_EXEC, S_GAP} state_t;
  state_t state, state_n;
  logic [INST_BITS-1:0] mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tcnt;
  logic store, pop, hit, done_inc, err_set;
  assign s_inst_ready = (queue_count < CW'(QUEUE_DEPTH)) && !flush;
  // idle-opcode words complete the handshake but never occupy a slot
  assign store = s_inst_valid && s_inst_ready && (s_inst_data[INST_BITS-1 -: OPCODE_BITS] != IDLE_OPCODE);
  assign hit = tcnt == TW'(ACCEPT_TIMEOUT - 1);
  assign busy = (state != S_IDLE) || (queue_count != '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == S_IDLE)   ? (pop ? S_ACCEPT : S_IDLE) :
              (state == S_ACCEPT) ? (!cu_idle_flag ? S_EXEC : hit ? S_GAP : S_ACCEPT) :
              (state == S_EXEC)   ? (cu_idle_flag ? S_GAP : S_EXEC) : S_IDLE;
  end
  always_comb begin
    pop = (state == S_IDLE) && (queue_count != '0) && cu_idle_flag;
    done_inc = (state == S_EXEC) && cu_idle_flag;
    err_set = (state == S_ACCEPT) && cu_idle_flag && hit;
  end
  always_ff @(posedge clk)
    if (store) mem[wr_ptr] <= s_inst_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_count <= '0;
      cu_instruction <= IDLE_WORD;
      done_count <= '0;
      err_timeout <= 1'b0;
      tcnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(store);
      // flush discards only entries not yet issued; a same-cycle pop still lands in cu_instruction
      rd_ptr <= flush ? wr_ptr : rd_ptr + PW'(pop);
      queue_count <= flush ? '0 : queue_count + CW'(store) - CW'(pop);
      cu_instruction <= pop ? mem[rd_ptr] : (done_inc || err_set) ? IDLE_WORD : cu_instruction;
      done_count <= done_count + 16'(done_inc);
      err_timeout <= err_timeout || err_set;
      tcnt <= pop ? '0 : (state == S_ACCEPT && cu_idle_flag) ? tcnt + 1'b1 : tcnt;
    end
endmodule

// File: tb/tb_inst_dispatcher.sv
// tb_inst_dispatcher: directed self-checking bench for inst_dispatcher
module tb_inst_dispatcher;
  logic clk = 0, reset_n = 0, s_inst_valid = 0, flush = 0, cu_idle_flag = 1;
  logic [67:0] s_inst_data = '0;
  logic s_inst_ready, busy, err_timeout;
  logic [67:0] cu_instruction;
  logic [3:0] queue_count;
  logic [15:0] done_count;
  int tests = 0, fails = 0;
  logic [67:0] exp_q[$];
  logic [15:0] done_ref;
  inst_dispatcher dut (
    .clk(clk), .reset_n(reset_n), .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready),
    .s_inst_data(s_inst_data), .flush(flush), .cu_idle_flag(cu_idle_flag),
    .cu_instruction(cu_instruction), .busy(busy), .queue_count(queue_count),
    .done_count(done_count), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return {op, a, b};
  endfunction
  task automatic push(input logic [67:0] d);
    s_inst_valid = 1;
    s_inst_data = d;
    tick;
    s_inst_valid = 0;
  endtask
  // control-unit model: accept each issued word, execute for two cycles, report idle
  task automatic run_cu(input int n);
    int got = 0, gap = 2, budget = 0;
    logic [67:0] e;
    cu_idle_flag = 1;
    while (got < n && budget < 3000) begin
      tick;
      budget++;
      if (cu_instruction[67:64] == 4'h0) gap++;
      else begin
        e = exp_q.pop_front();
        chk("issue_gap", 68'(gap >= 2), 68'd1);
        chk("issue_order", cu_instruction, e);
        cu_idle_flag = 0;
        tick;
        tick;
        chk("exec_hold", cu_instruction, e);
        cu_idle_flag = 1;
        tick;
        chk("exec_done_idle", cu_instruction, 68'h0);
        got++;
        gap = 1;
      end
    end
    chk("cu_budget", 68'(got), 68'(n));
  endtask
  initial begin
    tick;
    tick;
    reset_n = 1;
    chk("rst_cu", cu_instruction, 68'h0);
    chk("rst_count", 68'(queue_count), 68'd0);
    chk("rst_done", 68'(done_count), 68'd0);
    chk("rst_err", 68'(err_timeout), 68'd0);
    chk("rst_busy", 68'(busy), 68'd0);
    chk("rst_ready", 68'(s_inst_ready), 68'd1);
    // single instruction, latency and hold
    push(68'h1_00000010_00000020);
    chk("t1_count1", 68'(queue_count), 68'd1);
    chk("t1_not_yet", cu_instruction, 68'h0);
    tick;
    chk("t1_issued", cu_instruction, 68'h1_00000010_00000020);
    chk("t1_count0", 68'(queue_count), 68'd0);
    chk("t1_busy", 68'(busy), 68'd1);
    tick;
    tick;
    cu_idle_flag = 0;
    repeat (5) tick;
    chk("t1_hold", cu_instruction, 68'h1_00000010_00000020);
    cu_idle_flag = 1;
    tick;
    chk("t1_idle_word", cu_instruction, 68'h0);
    chk("t1_done", 68'(done_count), 68'd1);
    tick;
    chk("t1_busy_off", 68'(busy), 68'd0);
    // fill to full, ninth refused, then pop while full and refill
    cu_idle_flag = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("t2_ready_full", 68'(s_inst_ready), 68'd0);
      else begin
        chk("t2_ready", 68'(s_inst_ready), 68'd1);
        exp_q.push_back(mk(4'h2, 32'(i), 32'(100 + i)));
      end
      push(mk(4'h2, 32'(i), 32'(100 + i)));
    end
    chk("t2_count8", 68'(queue_count), 68'd8);
    chk("t2_cu_idle", cu_instruction, 68'h0);
    cu_idle_flag = 1;
    s_inst_valid = 1;
    s_inst_data = mk(4'h2, 32'hAA, 32'hBB);
    tick;
    chk("t3_pop_count7", 68'(queue_count), 68'd7);
    chk("t3_head", cu_instruction, exp_q[0]);
    tick;
    s_inst_valid = 0;
    chk("t3_refill8", 68'(queue_count), 68'd8);
    exp_q.push_back(mk(4'h2, 32'hAA, 32'hBB));
    run_cu(9);
    chk("t3_done", 68'(done_count), 68'd10);
    // simultaneous push and pop keeps the count
    cu_idle_flag = 0;
    tick;
    push(mk(4'h5, 32'h1, 32'h1));
    push(mk(4'h5, 32'h2, 32'h2));
    exp_q.push_back(mk(4'h5, 32'h1, 32'h1));
    exp_q.push_back(mk(4'h5, 32'h2, 32'h2));
    exp_q.push_back(mk(4'h5, 32'h3, 32'h3));
    cu_idle_flag = 1;
    push(mk(4'h5, 32'h3, 32'h3));
    chk("t3b_count", 68'(queue_count), 68'd2);
    chk("t3b_head", cu_instruction, mk(4'h5, 32'h1, 32'h1));
    run_cu(3);
    // idle-opcode pushes accepted but dropped
    cu_idle_flag = 0;
    tick;
    push(mk(4'h0, 32'h9, 32'h9));
    push(mk(4'h3, 32'hD1, 32'h1));
    push(mk(4'h0, 32'h8, 32'h8));
    push(mk(4'h3, 32'hD2, 32'h2));
    push(mk(4'h0, 32'h7, 32'h7));
    chk("t4_count", 68'(queue_count), 68'd2);
    exp_q.push_back(mk(4'h3, 32'hD1, 32'h1));
    exp_q.push_back(mk(4'h3, 32'hD2, 32'h2));
    run_cu(2);
    chk("t4_done", 68'(done_count), 68'd15);
    // accept timeout
    cu_idle_flag = 0;
    tick;
    push(mk(4'h7, 32'h71, 32'h1));
    push(mk(4'h7, 32'h72, 32'h2));
    cu_idle_flag = 1;
    tick;
    chk("t5_issued", cu_instruction, mk(4'h7, 32'h71, 32'h1));
    repeat (255) tick;
    chk("t5_err_early", 68'(err_timeout), 68'd0);
    chk("t5_still_held", cu_instruction, mk(4'h7, 32'h71, 32'h1));
    tick;
    chk("t5_err_set", 68'(err_timeout), 68'd1);
    chk("t5_idle_word", cu_instruction, 68'h0);
    chk("t5_done_same", 68'(done_count), 68'd15);
    exp_q.push_back(mk(4'h7, 32'h72, 32'h2));
    run_cu(1);
    chk("t5_done_next", 68'(done_count), 68'd16);
    chk("t5_err_sticky", 68'(err_timeout), 68'd1);
    // flush with one executing and three queued
    tick;
    push(mk(4'h9, 32'hE1, 32'h1));
    tick;
    chk("t6_exec", cu_instruction, mk(4'h9, 32'hE1, 32'h1));
    cu_idle_flag = 0;
    tick;
    push(mk(4'h9, 32'hF1, 32'h1));
    push(mk(4'h9, 32'hF2, 32'h2));
    push(mk(4'h9, 32'hF3, 32'h3));
    chk("t6_count3", 68'(queue_count), 68'd3);
    done_ref = done_count;
    flush = 1;
    s_inst_valid = 1;
    s_inst_data = mk(4'h9, 32'hF4, 32'h4);
    #1;
    chk("t6_ready_flush", 68'(s_inst_ready), 68'd0);
    tick;
    flush = 0;
    s_inst_valid = 0;
    chk("t6_count0", 68'(queue_count), 68'd0);
    chk("t6_exec_kept", cu_instruction, mk(4'h9, 32'hE1, 32'h1));
    cu_idle_flag = 1;
    tick;
    chk("t6_done_inc", 68'(done_count), 68'(done_ref + 16'd1));
    repeat (4) tick;
    chk("t6_no_issue", cu_instruction, 68'h0);
    chk("t6_busy", 68'(busy), 68'd0);
    // async reset mid-execution
    push(mk(4'hA, 32'h1, 32'h2));
    push(mk(4'hA, 32'h3, 32'h4));
    cu_idle_flag = 0;
    tick;
    chk("t7_exec", cu_instruction, mk(4'hA, 32'h1, 32'h2));
    #2;
    reset_n = 0;
    #1;
    chk("t7_cu", cu_instruction, 68'h0);
    chk("t7_count", 68'(queue_count), 68'd0);
    chk("t7_done", 68'(done_count), 68'd0);
    chk("t7_err", 68'(err_timeout), 68'd0);
    chk("t7_busy", 68'(busy), 68'd0);
    tick;
    reset_n = 1;
    cu_idle_flag = 1;
    repeat (3) tick;
    chk("t7_lost", cu_instruction, 68'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
